// File: rtl/paf_pkg.sv
// Shared types and constants for the fetch/PC stage.
package paf_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned PC_INC     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_mem_if.sv
// Instruction memory read handshake (req/ack).
//   master: drives mem_req/mem_addr, receives mem_ack/mem_rdata
//   slave : the memory side
interface fetch_mem_if #(
  parameter int unsigned ADDR_W = 32
);
  import paf_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select and alignment check.
//   in : pc, new_pc, offset (signed word offset), load_new_PC, sel_inc
//   out: next_pc, misaligned
// Macro FETCH_ALIGN_CHECK_EN: report unaligned targets instead of
// silently clearing bits [1:0].
module pc_next
  import paf_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic [15:0]       offset,
  input  logic              load_new_PC,
  input  logic              sel_inc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  logic [ADDR_W-1:0] rel_off;
  logic [ADDR_W-1:0] raw_pc;

  // Sign-extended word offset converted to a byte offset.
  assign rel_off = {{(ADDR_W-16){offset[15]}}, offset} << 2;

  always_comb begin
    raw_pc = new_pc;
    if (!load_new_PC) begin
      raw_pc = sel_inc ? (pc + ADDR_W'(PC_INC)) : (pc + rel_off);
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc    = raw_pc;
  assign misaligned = (raw_pc[1:0] != 2'b00);
`else
  // Forced word alignment means the result can never be misaligned.
  assign next_pc    = raw_pc & ~ADDR_W'(3);
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch + program counter stage driven by the multi-cycle
// controller strobes.
//   clk, reset_n                         : clock, async active-low reset
//   enable_PC/load_new_PC/sel_inc/link   : PC update controls
//   new_pc, offset                       : absolute / relative targets
//   enable_I                             : start fetch at current pc
//   mem                                  : instruction memory req/ack port
//   instr, opcode, instr_valid, busy     : IR and fetch status
//   pc, link_addr, link_valid            : PC and return address
//   misalign_err                         : sticky unaligned-target flag
// Macro FETCH_ALIGN_CHECK_EN enables the misaligned-target check.
module fetch_unit
  import paf_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable_PC,
  input  logic                load_new_PC,
  input  logic                sel_inc,
  input  logic                link,
  input  logic                enable_I,
  input  logic [ADDR_W-1:0]   new_pc,
  input  logic [15:0]         offset,
  fetch_mem_if.master         mem,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  output logic                busy,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   link_addr,
  output logic                link_valid,
  output logic                misalign_err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               mem_req_q, busy_q, instr_valid_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  link_addr_q, link_addr_d;
  logic               link_valid_q, link_valid_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  next_pc;
  logic               misaligned;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc_q),
    .new_pc      (new_pc),
    .offset      (offset),
    .load_new_PC (load_new_PC),
    .sel_inc     (sel_inc),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  // Fetch FSM next state; address latched on entry so PC updates don't disturb it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: if (enable_I) begin
        state_d = REQ;
        addr_d  = pc_q;
      end
      REQ: if (mem.mem_ack) begin
        state_d = DONE;
        ir_d    = mem.mem_rdata;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PC / link next state; link address uses the pre-update pc.
  always_comb begin
    pc_d         = pc_q;
    err_d        = err_q;
    link_addr_d  = link_addr_q;
    link_valid_d = 1'b0;
    if (enable_PC) begin
      if (misaligned) err_d = 1'b1;
      else            pc_d  = next_pc;
      if (link) begin
        link_addr_d  = pc_q + ADDR_W'(PC_INC);
        link_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      ir_q          <= '0;
      mem_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      link_addr_q   <= '0;
      link_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ir_q          <= ir_d;
      mem_req_q     <= (state_d == REQ);
      busy_q        <= (state_d != IDLE);
      instr_valid_q <= (state_d == DONE);
      pc_q          <= pc_d;
      link_addr_q   <= link_addr_d;
      link_valid_q  <= link_valid_d;
      err_q         <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_addr  = addr_q;
  assign instr         = ir_q;
  assign opcode        = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid   = instr_valid_q;
  assign busy          = busy_q;
  assign pc            = pc_q;
  assign link_addr     = link_addr_q;
  assign link_valid    = link_valid_q;
  assign misalign_err  = err_q;

endmodule
